// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: word width, buffer entry, RAM port op.
// No logic. Included by every file of the block.
package dmem_store_buffer_pkg;

  localparam int WORD_WIDTH = 32;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_LOAD,
    MEM_DRAIN
  } mem_op_e;

endpackage

// File: rtl/dmem_store_buffer_if.sv
// CPU load/store port plus backing-RAM port of the store buffer.
// slave = store buffer view, master = CPU/RAM environment view.
interface dmem_store_buffer_if
  import dmem_store_buffer_pkg::*;
#(
  parameter int W = WORD_WIDTH
) ();

  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         stall;
  logic         idle;
  logic         mem_en;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  modport slave (
    input  load_en, l_addr, store_en, s_addr, s_data, mem_rdata,
    output l_data, stall, idle, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output load_en, l_addr, store_en, s_addr, s_data, mem_rdata,
    input  l_data, stall, idle, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_store_buffer_sb_fifo.sv
// In-order store-buffer FIFO; all entries exposed for forwarding. Push/pop take effect at the edge.
// No internal backpressure: caller must not push when full nor pop when empty.
module sb_fifo
  import dmem_store_buffer_pkg::*;
#(
  parameter  int W     = WORD_WIDTH,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_addr,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_addr,
  output logic [W-1:0]  head_data,
  output logic [W-1:0]  ent_addr [DEPTH],
  output logic [W-1:0]  ent_data [DEPTH],
  output logic [AW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  addr_q [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [AW-1:0] tail;

  // Storage is not reset; count alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];
  assign ent_addr  = addr_q;
  assign ent_data  = data_q;

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between CPU data port and single-port RAM; loads win the RAM port, stores drain when idle.
// Load latency 1 cycle with youngest-store forwarding; stall when the buffer is full.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  dmem_store_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  head_addr;
  logic [W-1:0]  head_data;
  logic [W-1:0]  ent_addr [DEPTH];
  logic [W-1:0]  ent_data [DEPTH];
  logic [AW-1:0] head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  mem_op_e       op;

  logic          fwd_hit;
  logic [W-1:0]  fwd_data;
  logic [AW-1:0] idx;
  logic          load_pend_q;
  logic          fwd_hit_q;
  logic [W-1:0]  fwd_data_q;
  logic [W-1:0]  l_hold_q;
  logic [W-1:0]  l_result;

  assign push = bus.store_en && !full;

  sb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.s_addr),
    .push_data (bus.s_data),
    .pop       (op == MEM_DRAIN),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    op = MEM_IDLE;
    if (!rst) begin
      if (bus.load_en && !full) op = MEM_LOAD;
      else if (!empty)          op = MEM_DRAIN;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (op)
      MEM_LOAD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.l_addr;
      end
      MEM_DRAIN: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = head_addr;
        bus.mem_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (ent_addr[idx] == bus.l_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_pend_q <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      l_hold_q    <= '0;
    end else begin
      load_pend_q <= (op == MEM_LOAD);
      if (op == MEM_LOAD) begin
        fwd_hit_q  <= fwd_hit;
        fwd_data_q <= fwd_data;
      end
      if (load_pend_q) l_hold_q <= l_result;
    end
  end

  // RAM data is only valid the cycle after the read, so the result is captured to hold it.
  assign l_result   = fwd_hit_q ? fwd_data_q : bus.mem_rdata;
  assign bus.l_data = load_pend_q ? l_result : l_hold_q;
  assign bus.stall  = full;
  assign bus.idle   = empty && (op != MEM_DRAIN);

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed cases plus random traffic against a CPU-view memory model.
// The model tracks architectural memory and the pending-write order, not the buffer mechanics.
module tb_dmem_store_buffer;
  import dmem_store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dmem_store_buffer_if #(.W(WORD_WIDTH)) bus ();

  dmem_store_buffer #(.W(WORD_WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Backing RAM: synchronous single port, read data one cycle after the read.
  logic [31:0] ram [256] = '{default: '0};
  logic [31:0] rdata_q = '0;
  logic [31:0] log30 [$];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_addr == 32'h30) log30.push_back(bus.mem_wdata);
      end else begin
        rdata_q <= ram[bus.mem_addr[7:0]];
      end
    end
  end
  assign bus.mem_rdata = rdata_q;

  // Model: arch = what the CPU must see, mem_m = what the RAM must hold, wq = writes owed to the RAM.
  logic [31:0] arch  [256] = '{default: '0};
  logic [31:0] mem_m [256] = '{default: '0};
  sb_entry_t   wq [$];
  logic [31:0] exp_l = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic        full_m, ld, st, dr;
    logic [31:0] ea, ed;
    full_m = (wq.size() == DEPTH);
    ld = bus.load_en && !full_m;
    st = bus.store_en && !full_m;
    dr = !ld && (wq.size() > 0);
    ea = ld ? bus.l_addr : (dr ? wq[0].addr : 32'h0);
    ed = dr ? wq[0].data : 32'h0;
    chk("stall",     bus.stall,     full_m);
    chk("idle",      bus.idle,      (wq.size() == 0) && !dr);
    chk("mem_en",    bus.mem_en,    ld || dr);
    chk("mem_we",    bus.mem_we,    dr);
    chk("mem_addr",  bus.mem_addr,  ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    chk("l_data",    bus.l_data,    exp_l);
    if (ld) exp_l = arch[bus.l_addr[7:0]];
    if (dr) begin
      mem_m[wq[0].addr[7:0]] = wq[0].data;
      void'(wq.pop_front());
    end
    if (st) begin
      arch[bus.s_addr[7:0]] = bus.s_data;
      wq.push_back('{addr: bus.s_addr, data: bus.s_data});
    end
  endtask

  task automatic drive(input logic ld, input logic [31:0] la, input logic st,
                       input logic [31:0] sa, input logic [31:0] sd);
    bus.load_en  = ld;
    bus.l_addr   = la;
    bus.store_en = st;
    bus.s_addr   = sa;
    bus.s_data   = sd;
  endtask

  task automatic cyc(input logic ld, input logic [31:0] la, input logic st,
                     input logic [31:0] sa, input logic [31:0] sd);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(ld, la, st, sa, sd);
    #2;
    model_cycle();
  endtask

  task automatic idle_cyc(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic cyc_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #2;
    wq.delete();
    exp_l = '0;
    for (int k = 0; k < 256; k++) arch[k] = mem_m[k];
  endtask

  initial begin
    int          lg;
    logic        rl, rs;
    logic [31:0] ra, rsa;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc_rst();

    idle_cyc(1);
    chk("rst_stall",  bus.stall,     32'h0);
    chk("rst_idle",   bus.idle,      32'h1);
    chk("rst_l_data", bus.l_data,    32'h0);
    chk("rst_mem_en", bus.mem_en,    32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);

    // Store then drain on the following idle cycle.
    cyc(1'b0, 32'h0, 1'b1, 32'h10, 32'hAAAA);
    idle_cyc(1);
    chk("drain_we",    bus.mem_we,    32'h1);
    chk("drain_addr",  bus.mem_addr,  32'h10);
    chk("drain_wdata", bus.mem_wdata, 32'hAAAA);
    idle_cyc(1);
    chk("drain_idle",  bus.idle,      32'h1);

    // Forward from a buffered store.
    cyc(1'b0, 32'h0, 1'b1, 32'h20, 32'h1111);
    cyc(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    idle_cyc(1);
    chk("fwd_hit", bus.l_data, 32'h1111);
    idle_cyc(3);

    // Youngest of two matching stores wins; RAM sees them in order.
    lg = log30.size();
    cyc(1'b1, 32'h0, 1'b1, 32'h30, 32'h1);
    cyc(1'b1, 32'h0, 1'b1, 32'h30, 32'h2);
    cyc(1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
    idle_cyc(1);
    chk("fwd_youngest", bus.l_data, 32'h2);
    idle_cyc(4);
    chk("order_count", log30.size() - lg, 32'h2);
    chk("order_first", log30[lg], 32'h1);
    chk("order_second", log30[lg+1], 32'h2);

    // Continuous loads fill the buffer; full forces a drain.
    cyc(1'b1, 32'h0, 1'b1, 32'h50, 32'hA0);
    cyc(1'b1, 32'h0, 1'b1, 32'h51, 32'hA1);
    cyc(1'b1, 32'h0, 1'b1, 32'h52, 32'hA2);
    cyc(1'b1, 32'h0, 1'b1, 32'h53, 32'hA3);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("full_stall",  bus.stall,    32'h1);
    chk("full_mem_we", bus.mem_we,   32'h1);
    chk("full_addr",   bus.mem_addr, 32'h50);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("unstall", bus.stall, 32'h0);
    idle_cyc(6);

    // Same-cycle store and load to one address returns the old value.
    cyc(1'b0, 32'h0, 1'b1, 32'h40, 32'h9);
    idle_cyc(2);
    cyc(1'b1, 32'h40, 1'b1, 32'h40, 32'h5);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    chk("same_cycle_old", bus.l_data, 32'h9);
    idle_cyc(1);
    chk("next_load_new", bus.l_data, 32'h5);
    idle_cyc(3);

    // Reset discards buffered stores and the pending load result.
    cyc(1'b1, 32'h40, 1'b1, 32'h60, 32'hB0);
    cyc(1'b1, 32'h40, 1'b1, 32'h61, 32'hB1);
    cyc(1'b1, 32'h40, 1'b1, 32'h62, 32'hB2);
    cyc_rst();
    idle_cyc(1);
    chk("rst2_idle",   bus.idle,   32'h1);
    chk("rst2_l_data", bus.l_data, 32'h0);
    chk("rst2_stall",  bus.stall,  32'h0);
    idle_cyc(4);
    chk("rst2_no_wr60", ram[8'h60], 32'h0);
    chk("rst2_no_wr61", ram[8'h61], 32'h0);
    chk("rst2_no_wr62", ram[8'h62], 32'h0);

    // Random traffic over a small address window to provoke hits and stalls.
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) begin
        cyc_rst();
      end else begin
        rl  = ($urandom_range(0, 99) < 45);
        rs  = ($urandom_range(0, 99) < 50);
        ra  = 32'h80 + 32'($urandom_range(0, 7));
        rsa = 32'h80 + 32'($urandom_range(0, 7));
        cyc(rl, ra, rs, rsa, $urandom);
      end
    end
    idle_cyc(8);
    for (int a = 8'h80; a < 8'h88; a++) chk("ram_final", ram[a], mem_m[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Memory-side responder for the CPU's data load/store port. It accepts CPU stores into a small in-order store buffer and drains them one per cycle into a single-port synchronous backing RAM. It services CPU loads from that RAM, forwarding data from any buffered store to the same address. It sits between the CPU core and the data RAM, and asserts a stall when it cannot accept a request.

## Interface
- `W`, default `WORD_WIDTH` (32): data and address width.
- `DEPTH`, default 4: number of store-buffer entries. Must be a power of two and at least 2.
- `clk`, in, 1: single clock; all state changes on the posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `load_en`, in, 1: CPU load request this cycle.
- `l_addr`, in, W: load word address.
- `l_data`, out, W: load result, registered.
- `store_en`, in, 1: CPU store request this cycle.
- `s_addr`, in, W: store word address.
- `s_data`, in, W: store data.
- `stall`, out, 1: buffer full; the CPU must hold its requests.
- `idle`, out, 1: buffer empty and no RAM write in flight.
- `mem_en`, out, 1: backing RAM access enable.
- `mem_we`, out, 1: RAM write (1) or read (0).
- `mem_addr`, out, W: RAM address.
- `mem_wdata`, out, W: RAM write data.
- `mem_rdata`, in, W: RAM read data, valid one cycle after a read.

## Operation
- Access granularity is full words only; there are no byte enables.
- The buffer is a FIFO of {addr, data} entries, tracked by `count` (0..DEPTH) with wrapping head and tail pointers.
- `stall` = (`count` == DEPTH), decoded from registered state only.
- While `stall`=1, `load_en` and `store_en` are ignored. The CPU is responsible for holding the request and re-presenting it.
- Store accept: when `store_en` and not `stall`, write {`s_addr`,`s_data`} at the tail and advance the tail.
- RAM port arbitration, per cycle:
  - A load (`load_en` and not `stall`) wins: `mem_en`=1, `mem_we`=0, `mem_addr`=`l_addr`.
  - Otherwise, if `count`>0: drain the head entry with `mem_en`=1, `mem_we`=1, address and data from the head, then advance the head.
  - Otherwise, `mem_en`=0.
- Count update: +1 on accept, −1 on drain, unchanged when both happen in the same cycle.
- Load forwarding:
  - In the cycle of the load, compare `l_addr` against all valid entries, using pre-edge buffer contents.
  - On a hit, the youngest matching entry's data is registered as the forward value.
  - On a miss, `l_data` is taken from `mem_rdata`.
- Store and load to the same address in the same cycle: the load returns the old value. The new store is not yet visible.
- `idle` = (`count`==0) and no drain issued this cycle.

## Timing
- Load latency is 1 cycle. If a load is issued in cycle N, `l_data` is valid in cycle N+1, then held stable until the next accepted load's result.
- Forward-hit select is registered in cycle N and drives the output mux in cycle N+1.
- Store visibility:
  - Forwardable from cycle N+1 after acceptance in cycle N.
  - Written to the RAM at the earliest cycle with no load and with all older entries drained.
- Continuous loads starve the drain until the buffer fills. At that point `stall` blocks loads and the drain proceeds, guaranteeing forward progress.
- Full with a drain in the same cycle: `stall` is still 1 in that cycle, so no store is accepted. `stall` drops the next cycle.
- Reset values: `count`=0, both pointers 0, `stall`=0, `idle`=1, `l_data`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation discards all buffered stores without writing them, and discards any pending load result.

## Structure
- Shared package (alongside `defines.v`): `WORD_WIDTH` and the store-buffer entry type {addr, data}.
- Sub-module `sb_fifo` holds the entries, pointers, count, and full/empty flags, and exposes all entries for the forwarding compare.
- The top of `dmem_store_buffer` contains arbitration, the forward compare with youngest-match priority, and the `l_data` register and mux.

## Test plan
- Store 0x10←0xAAAA, idle for 1 cycle → cycle after acceptance shows `mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0xAAAA; `idle`=1 afterwards.
- Store 0x20←0x1111, then load 0x20 on the next cycle while the entry is still buffered (preceding load prevents drain) → `l_data`=0x1111 one cycle after the load.
- Stores 0x30←1 then 0x30←2, both buffered, then load 0x30 → `l_data`=2 (youngest wins); RAM receives 1 then 2 in order.
- With loads every cycle, issue 4 stores → `stall`=1 with `count`=4; loads are ignored, the drain writes the oldest entry, and `stall`=0 the following cycle.
- Same-cycle store 0x40←5 and load 0x40, with RAM holding 9 → `l_data`=9; a load next cycle returns 5.
- Buffer 3 entries, assert `rst` for 1 cycle → no RAM writes occur; `count`=0, `idle`=1, `l_data`=0.
